// File: rtl/cache_refill_pkg.sv
// Shared types and default sizing for the cache refill controller.
// CACHE_REFILL_WRITEBACK_EN selects a write-back cache; leave it undefined for write-through.
package cache_refill_pkg;

  localparam int unsigned DEFNUMWAYS      = 4;
  localparam int unsigned DEFBEATSPERLINE = 4;
  localparam int unsigned LOGBEATS        = $clog2(DEFBEATSPERLINE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EVICT     = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    COMMIT    = 3'd4,
    DONE      = 3'd5
  } refillState_t;

endpackage

// File: rtl/cache_refill_if.sv
// Pipeline, replacement-logic and bus signals shared by the refill controller.
// master is the controller side; slave is the pipeline/bus environment side.
interface cache_refill_if #(
  parameter int unsigned NUMWAYS      = cache_refill_pkg::DEFNUMWAYS,
  parameter int unsigned BEATSPERLINE = cache_refill_pkg::DEFBEATSPERLINE
);
  localparam int unsigned LogBeats = $clog2(BEATSPERLINE);

  logic                Miss;
  logic                FlushStage;
  logic [NUMWAYS-1:0]  VictimWay;
  logic                VictimDirty;
  logic                BusAck;
  logic                BusReq;
  logic                BusWrite;
  logic [LogBeats-1:0] BeatCount;
  logic [NUMWAYS-1:0]  FillWay;
  logic                LRUWriteEn;
  logic                ClearValid;
  logic                SetValid;
  logic                ClearDirty;
  logic                Stall;

  modport master (
    input  Miss, FlushStage, VictimWay, VictimDirty, BusAck,
    output BusReq, BusWrite, BeatCount, FillWay,
           LRUWriteEn, ClearValid, SetValid, ClearDirty, Stall
  );

  modport slave (
    output Miss, FlushStage, VictimWay, VictimDirty, BusAck,
    input  BusReq, BusWrite, BeatCount, FillWay,
           LRUWriteEn, ClearValid, SetValid, ClearDirty, Stall
  );
endinterface

// File: rtl/cache_refill_ctrl_beat.sv
// Beat counter for line transfers: counts acknowledged beats and wraps to 0 after the last.
module cache_beat_counter #(
  parameter int unsigned BEATSPERLINE = cache_refill_pkg::DEFBEATSPERLINE,
  parameter int unsigned W            = cache_refill_pkg::LOGBEATS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         lastBeat_c
);

  assign lastBeat_c = (count == W'(BEATSPERLINE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= lastBeat_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill sequencer: evict victim, optional writeback, line fill, tag commit.
// CACHE_REFILL_WRITEBACK_EN enables the dirty-victim writeback path.
module cache_refill_ctrl #(
  parameter int unsigned NUMWAYS      = cache_refill_pkg::DEFNUMWAYS,
  parameter int unsigned BEATSPERLINE = cache_refill_pkg::DEFBEATSPERLINE
) (
  input  logic           clk,
  input  logic           reset_n,
  cache_refill_if.master bus
);
  import cache_refill_pkg::*;

  localparam int unsigned BeatW = $clog2(BEATSPERLINE);

  refillState_t       state, stateNext;
  logic [NUMWAYS-1:0] fillWayQ;
  logic [BeatW-1:0]   beatCount;
  logic               missAccept_c, beatAck_c, beatClr_c, lastBeat_c;
  logic               lruWriteEn_c, clearValid_c, setValid_c, clearDirty_c;
  logic               busReq_c, busWrite_c, stall_c;

  assign missAccept_c = (state == IDLE) && bus.Miss && !bus.FlushStage;
  assign beatAck_c    = bus.BusAck && ((state == WRITEBACK) || (state == FILL));
  assign beatClr_c    = (state == IDLE);

  cache_beat_counter #(
    .BEATSPERLINE(BEATSPERLINE),
    .W           (BeatW)
  ) uBeatCounter (
    .clk       (clk),
    .reset_n   (reset_n),
    .inc       (beatAck_c),
    .clr       (beatClr_c),
    .count     (beatCount),
    .lastBeat_c(lastBeat_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Victim way is captured only when a miss is accepted; later changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          fillWayQ <= '0;
    else if (missAccept_c) fillWayQ <= bus.VictimWay;
  end

`ifdef CACHE_REFILL_WRITEBACK_EN
  logic dirtyQ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          dirtyQ <= 1'b0;
    else if (missAccept_c) dirtyQ <= bus.VictimDirty;
  end
`else
  logic unusedDirty;
  assign unusedDirty = bus.VictimDirty;
`endif

  always_comb begin
    stateNext    = state;
    lruWriteEn_c = 1'b0;
    clearValid_c = 1'b0;
    setValid_c   = 1'b0;
    clearDirty_c = 1'b0;
    busReq_c     = 1'b0;
    busWrite_c   = 1'b0;
    stall_c      = 1'b0;
    unique case (state)
      IDLE: begin
        // Stall follows Miss here; gated so it reads 0 throughout reset.
        stall_c = bus.Miss && reset_n;
        if (missAccept_c) stateNext = EVICT;
      end
      EVICT: begin
        stall_c = 1'b1;
        if (bus.FlushStage) begin
          stateNext = IDLE;
        end else begin
          lruWriteEn_c = 1'b1;
          clearValid_c = 1'b1;
`ifdef CACHE_REFILL_WRITEBACK_EN
          stateNext    = dirtyQ ? WRITEBACK : FILL;
`else
          stateNext    = FILL;
`endif
        end
      end
`ifdef CACHE_REFILL_WRITEBACK_EN
      WRITEBACK: begin
        stall_c    = 1'b1;
        busReq_c   = 1'b1;
        busWrite_c = 1'b1;
        if (beatAck_c && lastBeat_c) stateNext = FILL;
      end
`endif
      FILL: begin
        stall_c  = 1'b1;
        busReq_c = 1'b1;
        if (beatAck_c && lastBeat_c) stateNext = COMMIT;
      end
      COMMIT: begin
        stall_c    = 1'b1;
        setValid_c = 1'b1;
`ifdef CACHE_REFILL_WRITEBACK_EN
        clearDirty_c = 1'b1;
`endif
        stateNext  = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign bus.BusReq     = busReq_c;
  assign bus.BusWrite   = busWrite_c;
  assign bus.BeatCount  = beatCount;
  assign bus.FillWay    = fillWayQ;
  assign bus.LRUWriteEn = lruWriteEn_c;
  assign bus.ClearValid = clearValid_c;
  assign bus.SetValid   = setValid_c;
  assign bus.ClearDirty = clearDirty_c;
  assign bus.Stall      = stall_c;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl; the reference derives per-cycle expectations
// from miss start, victim dirtiness and the applied BusAck pattern.
module tb_cache_refill_ctrl;
  localparam int unsigned NW   = 4;
  localparam int unsigned NB   = 4;
  localparam int          MAXC = 64;
`ifdef CACHE_REFILL_WRITEBACK_EN
  localparam bit WbEn = 1'b1;
`else
  localparam bit WbEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [NW-1:0] lastWay = '0;

  always #5 clk = ~clk;

  cache_refill_if #(.NUMWAYS(NW), .BEATSPERLINE(NB)) bus ();

  cache_refill_ctrl #(.NUMWAYS(NW), .BEATSPERLINE(NB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic logic [NW-1:0] randOneHot();
    logic [NW-1:0] v;
    int idx;
    v = '0;
    idx = int'($urandom_range(0, NW - 1));
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive(input logic m, input logic f, input logic [NW-1:0] w, input logic d, input logic a);
    bus.Miss        = m;
    bus.FlushStage  = f;
    bus.VictimWay   = w;
    bus.VictimDirty = d;
    bus.BusAck      = a;
  endtask

  // One miss from IDLE back to IDLE. ackMode: 0 ack always, 1 ack on odd cycles, 2 random.
  task automatic run_miss(input string tag, input logic [NW-1:0] way, input logic dirty, input int ackMode,
                          input bit flushBus, input logic [NW-1:0] altWay, input bit noise);
    logic ack [MAXC];
    int e, wbEnd, nBeats, acks;
    bit d;
    d      = dirty && WbEn;
    nBeats = d ? 2 * NB : NB;
    for (int c = 0; c < MAXC; c++) begin
      case (ackMode)
        0:       ack[c] = 1'b1;
        1:       ack[c] = ((c % 2) == 1);
        default: ack[c] = rbit();
      endcase
      if (c >= 40) ack[c] = 1'b1;
    end
    // Bus phase starts two cycles after the miss and ends on the last required ack.
    acks = 0; e = 0; wbEnd = 0;
    for (int c = 2; c < MAXC && e == 0; c++) begin
      if (ack[c]) begin
        acks++;
        if (acks == NB) wbEnd = c;
        if (acks == nBeats) e = c;
      end
    end
    acks = 0;
    for (int c = 0; c <= e + 3; c++) begin
      logic m, f, vd, expStall, expLru, expReq, expWr, expSet, expClrD;
      logic [NW-1:0] w, expWay;
      logic [1:0] expBeat;
      m  = (c <= e + 1) ? 1'b1 : ((c == e + 2) ? rbit() : 1'b0);
      f  = (c >= 2 && c <= e) && (flushBus ? 1'b1 : (noise ? rbit() : 1'b0));
      w  = (c == 0) ? way : (noise ? randOneHot() : altWay);
      vd = (c == 0) ? dirty : rbit();
      @(negedge clk);
      drive(m, f, w, vd, ack[c]);
      #1;
      expStall = (c <= e + 1);
      expLru   = (c == 1);
      expReq   = (c >= 2 && c <= e);
      expWr    = d && (c >= 2 && c <= wbEnd);
      expBeat  = expReq ? 2'(acks % NB) : 2'd0;
      expSet   = (c == e + 1);
      expClrD  = d && (c == e + 1);
      expWay   = (c == 0) ? lastWay : way;
      checks++; if (bus.Stall !== expStall) begin errors++; $display("FAIL %s c%0d Stall got %b exp %b", tag, c, bus.Stall, expStall); end
      checks++; if (bus.LRUWriteEn !== expLru) begin errors++; $display("FAIL %s c%0d LRUWriteEn got %b exp %b", tag, c, bus.LRUWriteEn, expLru); end
      checks++; if (bus.ClearValid !== expLru) begin errors++; $display("FAIL %s c%0d ClearValid got %b exp %b", tag, c, bus.ClearValid, expLru); end
      checks++; if (bus.BusReq !== expReq) begin errors++; $display("FAIL %s c%0d BusReq got %b exp %b", tag, c, bus.BusReq, expReq); end
      checks++; if (bus.BusWrite !== expWr) begin errors++; $display("FAIL %s c%0d BusWrite got %b exp %b", tag, c, bus.BusWrite, expWr); end
      checks++; if (bus.BeatCount !== expBeat) begin errors++; $display("FAIL %s c%0d BeatCount got %0d exp %0d", tag, c, bus.BeatCount, expBeat); end
      checks++; if (bus.SetValid !== expSet) begin errors++; $display("FAIL %s c%0d SetValid got %b exp %b", tag, c, bus.SetValid, expSet); end
      checks++; if (bus.ClearDirty !== expClrD) begin errors++; $display("FAIL %s c%0d ClearDirty got %b exp %b", tag, c, bus.ClearDirty, expClrD); end
      checks++; if (bus.FillWay !== expWay) begin errors++; $display("FAIL %s c%0d FillWay got %b exp %b", tag, c, bus.FillWay, expWay); end
      if (c >= 2 && c <= e && ack[c]) acks++;
    end
    lastWay = way;
  endtask

  task automatic check_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, rbit(), randOneHot(), rbit(), rbit());
      #1;
      checks++; if (bus.SetValid !== 1'b0) begin errors++; $display("FAIL %s i%0d SetValid got %b exp 0", tag, i, bus.SetValid); end
      checks++; if (bus.BusReq !== 1'b0) begin errors++; $display("FAIL %s i%0d BusReq got %b exp 0", tag, i, bus.BusReq); end
      checks++; if (bus.LRUWriteEn !== 1'b0) begin errors++; $display("FAIL %s i%0d LRUWriteEn got %b exp 0", tag, i, bus.LRUWriteEn); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, rbit(), randOneHot(), rbit(), 1'b1);
      #1;
      checks++;
      if ({bus.BusReq, bus.BusWrite, bus.LRUWriteEn, bus.ClearValid, bus.SetValid, bus.ClearDirty, bus.Stall} !== 7'b0 ||
          bus.BeatCount !== 2'd0 || bus.FillWay !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold req=%b wr=%b lru=%b cv=%b sv=%b cd=%b stall=%b beat=%0d way=%b exp all 0",
                 bus.BusReq, bus.BusWrite, bus.LRUWriteEn, bus.ClearValid, bus.SetValid, bus.ClearDirty,
                 bus.Stall, bus.BeatCount, bus.FillWay);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
    lastWay = '0;
    check_quiet("reset_release", 3);
  endtask

  task automatic test_flush_evict();
    logic [NW-1:0] way;
    way = randOneHot();
    @(negedge clk); drive(1'b1, 1'b0, way, 1'b1, 1'b1); #1;
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL flush_evict idle Stall got %b exp 1", bus.Stall); end
    @(negedge clk); drive(1'b1, 1'b1, randOneHot(), 1'b1, 1'b1); #1;
    checks++; if (bus.LRUWriteEn !== 1'b0 || bus.ClearValid !== 1'b0) begin errors++; $display("FAIL flush_evict strobes lru=%b cv=%b exp 0 0", bus.LRUWriteEn, bus.ClearValid); end
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL flush_evict evict Stall got %b exp 1", bus.Stall); end
    @(negedge clk); drive(1'b0, 1'b0, randOneHot(), 1'b0, 1'b1); #1;
    checks++; if (bus.BusReq !== 1'b0 || bus.Stall !== 1'b0) begin errors++; $display("FAIL flush_evict back_idle req=%b stall=%b exp 0 0", bus.BusReq, bus.Stall); end
    checks++; if (bus.FillWay !== way) begin errors++; $display("FAIL flush_evict FillWay got %b exp %b", bus.FillWay, way); end
    lastWay = way;
    check_quiet("flush_evict_after", 8);
  endtask

  task automatic test_reset_midfill();
    @(negedge clk); drive(1'b1, 1'b0, 4'b0100, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b1, 1'b0, 4'b0001, 1'b0, 1'b1);
    end
    #1;
    checks++; if (bus.BusReq !== 1'b1 || bus.BeatCount !== 2'd2) begin errors++; $display("FAIL reset_midfill pre req=%b beat=%0d exp 1 2", bus.BusReq, bus.BeatCount); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.BusReq, bus.BusWrite, bus.LRUWriteEn, bus.ClearValid, bus.SetValid, bus.ClearDirty, bus.Stall} !== 7'b0 ||
        bus.BeatCount !== 2'd0 || bus.FillWay !== 4'd0) begin
      errors++;
      $display("FAIL reset_midfill drop req=%b stall=%b sv=%b beat=%0d way=%b exp all 0",
               bus.BusReq, bus.Stall, bus.SetValid, bus.BeatCount, bus.FillWay);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    reset_n = 1'b1;
    lastWay = '0;
    check_quiet("reset_midfill_after", 10);
  endtask

  task automatic test_clean_miss();      run_miss("clean_miss", 4'b0100, 1'b0, 0, 1'b0, 4'b0001, 1'b0); endtask
  task automatic test_dirty_miss();      run_miss("dirty_miss", 4'b0010, 1'b1, 0, 1'b0, 4'b0001, 1'b0); endtask
  task automatic test_ack_toggle();      run_miss("ack_toggle", 4'b0100, 1'b0, 1, 1'b0, 4'b0001, 1'b0); endtask
  task automatic test_flush_fill();      run_miss("flush_fill", 4'b1000, 1'b1, 1, 1'b1, 4'b0001, 1'b0); endtask

  task automatic test_back_to_back();
    run_miss("b2b_a", 4'b0001, 1'b1, 0, 1'b0, 4'b1000, 1'b0);
    run_miss("b2b_b", 4'b1000, 1'b0, 0, 1'b0, 4'b0001, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) run_miss("random", randOneHot(), rbit(), 2, 1'b0, '0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_ack_toggle();
    test_flush_evict();
    test_flush_fill();
    test_back_to_back();
    test_random();
    test_reset_midfill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
